// File: rtl/arp_tx_ctrl_if.sv
// Frame-control bus between the ARP transmit scheduler and the ARP transmitter.
interface arp_tx_ctrl_if;
    logic        arp_tx_en;
    logic        arp_tx_op;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        arp_tx_done;

    modport master (output arp_tx_en, arp_tx_op, des_mac, des_ip, input arp_tx_done);
    modport slave  (input arp_tx_en, arp_tx_op, des_mac, des_ip, output arp_tx_done);
endinterface

// File: rtl/arp_tx_ctrl.sv
// Schedules ARP replies (priority) and requests onto the transmitter, holding frame
// fields stable, enforcing an inter-frame gap, aborting hung frames and counting traffic.
module arp_tx_ctrl #(
    parameter int unsigned IFG_CYCLES    = 12,
    parameter int unsigned PERIOD_CYCLES = 0,
    parameter int unsigned TX_TIMEOUT    = 128,
    parameter logic [31:0] TARGET_IP     = 32'hac_1c_4a_90
) (
    input  logic          arp_tx_clk,
    input  logic          rstn,
    input  logic          rx_req_valid,
    input  logic [47:0]   rx_src_mac,
    input  logic [31:0]   rx_src_ip,
    input  logic          user_req,
    arp_tx_ctrl_if.master tx,
    output logic          busy,
    output logic          tx_timeout,
    output logic [15:0]   reply_cnt,
    output logic [15:0]   request_cnt,
    output logic [15:0]   drop_cnt
);

    localparam int unsigned WD_W     = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam int unsigned GAP_W    = $clog2(IFG_CYCLES + 1);
    localparam int unsigned TMR_W    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned TMR_LAST = (PERIOD_CYCLES == 0) ? 0 : PERIOD_CYCLES - 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state;
    state_t             state_next;
    logic               pend_rep;
    logic               pend_req;
    logic [47:0]        rep_mac;
    logic [31:0]        rep_ip;
    logic [WD_W-1:0]    wd_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TMR_W-1:0]   period_tmr;
    logic               timer_fire;
    logic               launch_rep;
    logic               launch_req;
    logic               frame_end;
    logic               frame_abort;

    assign busy       = (state != IDLE);
    assign timer_fire = (PERIOD_CYCLES != 0) && (period_tmr == TMR_W'(TMR_LAST));

    always_ff @(posedge arp_tx_clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        launch_rep  = 1'b0;
        launch_req  = 1'b0;
        frame_end   = 1'b0;
        frame_abort = 1'b0;
        case (state)
            IDLE: begin
                if (pend_rep) begin
                    launch_rep = 1'b1;
                    state_next = SEND;
                end else if (pend_req) begin
                    launch_req = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (tx.arp_tx_done) begin
                    frame_end  = 1'b1;
                    state_next = GAP;
                end else if (wd_cnt == WD_W'(TX_TIMEOUT - 1)) begin
                    frame_abort = 1'b1;
                    state_next  = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A launch reads the old buffer while a same-cycle pulse re-arms it, so that is not a drop.
    always_ff @(posedge arp_tx_clk) begin
        if (!rstn) begin
            pend_rep <= 1'b0;
            pend_req <= 1'b0;
            rep_mac  <= '0;
            rep_ip   <= '0;
            drop_cnt <= '0;
        end else begin
            if (rx_req_valid) begin
                pend_rep <= 1'b1;
                rep_mac  <= rx_src_mac;
                rep_ip   <= rx_src_ip;
                if (pend_rep && !launch_rep) drop_cnt <= drop_cnt + 16'd1;
            end else if (launch_rep) begin
                pend_rep <= 1'b0;
            end
            if (user_req || timer_fire) pend_req <= 1'b1;
            else if (launch_req)        pend_req <= 1'b0;
        end
    end

    always_ff @(posedge arp_tx_clk) begin
        if (!rstn || timer_fire || PERIOD_CYCLES == 0) period_tmr <= '0;
        else                                           period_tmr <= period_tmr + 1'b1;
    end

    // en falls on the done edge itself so the transmitter never re-triggers.
    always_ff @(posedge arp_tx_clk) begin
        if (!rstn) begin
            tx.arp_tx_en <= 1'b0;
            tx.arp_tx_op <= 1'b0;
            tx.des_mac   <= '0;
            tx.des_ip    <= '0;
            tx_timeout   <= 1'b0;
            wd_cnt       <= '0;
            gap_cnt      <= '0;
            reply_cnt    <= '0;
            request_cnt  <= '0;
        end else begin
            tx_timeout <= frame_abort;
            if (launch_rep) begin
                tx.arp_tx_en <= 1'b1;
                tx.arp_tx_op <= 1'b0;
                tx.des_mac   <= rep_mac;
                tx.des_ip    <= rep_ip;
            end else if (launch_req) begin
                tx.arp_tx_en <= 1'b1;
                tx.arp_tx_op <= 1'b1;
                tx.des_mac   <= '1;
                tx.des_ip    <= TARGET_IP;
            end else if (frame_end || frame_abort) begin
                tx.arp_tx_en <= 1'b0;
            end

            if (state == SEND) wd_cnt <= wd_cnt + 1'b1;
            else               wd_cnt <= '0;

            if (frame_end || frame_abort)              gap_cnt <= GAP_W'(IFG_CYCLES - 1);
            else if (state == GAP && gap_cnt != '0)    gap_cnt <= gap_cnt - 1'b1;

            if (frame_end) begin
                if (tx.arp_tx_op) request_cnt <= request_cnt + 16'd1;
                else              reply_cnt   <= reply_cnt + 16'd1;
            end
        end
    end

endmodule
